// File: rtl/multisim_tx_serializer.sv
// Transmit-side width adapter: accepts one wide word per valid/ready handshake
// and emits it LSB-chunk first as CHUNK_WIDTH beats, flagging the final beat.
module multisim_tx_serializer #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned CHUNK_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [CHUNK_WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic [31:0]            word_cnt
);

  localparam int unsigned NumBeats = (DATA_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int unsigned IdxWidth = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned WordWidth = NumBeats * CHUNK_WIDTH;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumBeats - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e                 r_state, w_state_nxt;
  logic [IdxWidth-1:0]    r_idx, w_idx_nxt;
  logic [WordWidth-1:0]   r_word, w_word_nxt;
  logic [31:0]            r_word_cnt, w_word_cnt_nxt;

  logic [WordWidth-1:0]   w_in_ext;
  logic [CHUNK_WIDTH-1:0] w_beat;
  logic                   w_last;
  logic                   w_in_rdy;
  logic                   w_xfer;

  // Zero-extend the input word to a whole number of chunks.
  always_comb begin
    w_in_ext = '0;
    w_in_ext[DATA_WIDTH-1:0] = in_data;
  end

  // Select the chunk addressed by the beat index (constant slices only).
  always_comb begin
    w_beat = '0;
    for (int i = 0; i < int'(NumBeats); i++) begin
      if (r_idx == IdxWidth'(i)) begin
        w_beat = r_word[i*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
  end

  assign w_last   = (r_idx == LastIdx);
  assign out_vld  = (r_state == StSend);
  assign out_last = out_vld && w_last;
  assign out_data = out_vld ? w_beat : '0;
  assign word_cnt = r_word_cnt;
  assign w_xfer   = out_vld && out_rdy;
  // Reset gates acceptance combinationally so nothing is taken while rst is high.
  assign in_rdy   = w_in_rdy && !rst;

  // Next-state logic: capture, beat advance, word completion and back-to-back reload.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_word_nxt     = r_word;
    w_word_cnt_nxt = r_word_cnt;
    w_in_rdy       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_in_rdy = 1'b1;
        if (in_vld) begin
          w_word_nxt  = w_in_ext;
          w_idx_nxt   = '0;
          w_state_nxt = StSend;
        end
      end
      StSend: begin
        // A new word may only enter on the same edge the last beat leaves.
        w_in_rdy = out_rdy && w_last;
        if (w_xfer) begin
          if (w_last) begin
            w_word_cnt_nxt = r_word_cnt + 32'd1;
            w_idx_nxt      = '0;
            if (in_vld) begin
              w_word_nxt = w_in_ext;
            end else begin
              w_state_nxt = StIdle;
            end
          end else begin
            w_idx_nxt = r_idx + IdxWidth'(1);
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; a word in flight is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_word     <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_word     <= w_word_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

endmodule
